// File: rtl/fft_butterfly.sv
// rtl/fft_butterfly.sv - pipelined radix-2 DIT butterfly x = a + b*W, y = a - b*W
// Optional 1/2 per-stage scaling with round-half-up when BFLY_SCALE_EN is defined.
module fft_butterfly #(
  parameter int WIDTH    = 16,
  parameter int TW_WIDTH = 16,
  parameter int INVERSE  = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [TW_WIDTH-1:0] tw,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    x,
  output logic [WIDTH-1:0]    y,
  output logic                sat_flag,
  input  logic                sat_clear
);
  localparam int H  = WIDTH / 2;
  localparam int TH = TW_WIDTH / 2;
  localparam int PW = H + TH + 1;
  localparam int SW = H + TH + 2;
  localparam int RW = H + 2;

  logic en;
  logic v1, v2, v3, v4;

  logic signed [TH:0]   wr_in, wi_in;
  logic [H-1:0]         s1_ar, s1_ai, s1_br, s1_bi;
  logic signed [TH:0]   s1_wr, s1_wi;
  logic [H-1:0]         s2_ar, s2_ai;
  logic signed [PW-1:0] s2_rr, s2_ii, s2_ir, s2_ri;
  logic signed [SW-1:0] sum_r, sum_i, sh_r, sh_i;
  logic [H-1:0]         s3_ar, s3_ai;
  logic signed [RW-1:0] s3_tr, s3_ti;
  logic signed [RW-1:0] ea_r, ea_i, xs_r, xs_i, ys_r, ys_i;
  logic [H:0]           xr_s, xi_s, yr_s, yi_s;
  logic                 sat_ev;

  assign en        = !v4 || out_ready;
  assign in_ready  = en;
  assign out_valid = v4;

  function automatic logic signed [PW-1:0] mul(input logic [H-1:0] s, input logic signed [TH:0] w);
    logic signed [PW-1:0] se, we;
    se = {{(PW-H){s[H-1]}}, s};
    we = {{(PW-TH-1){w[TH]}}, w};
    return se * we;
  endfunction

  function automatic logic signed [SW-1:0] ext_p(input logic signed [PW-1:0] p);
    return {p[PW-1], p};
  endfunction

  // Returns {saturated, value}; in range when the top three bits agree.
  function automatic logic [H:0] sat_h(input logic [RW-1:0] v);
    if (v[RW-1:H-1] == {(RW-H+1){1'b0}} || v[RW-1:H-1] == {(RW-H+1){1'b1}})
      return {1'b0, v[H-1:0]};
    return {1'b1, v[RW-1], {(H-1){~v[RW-1]}}};
  endfunction

  // The lookup encodes cos = 1.0 as the most negative code; read it back as +1.0.
  always_comb begin
    wr_in = {tw[TH-1], tw[TH-1:0]};
    wi_in = {tw[TW_WIDTH-1], tw[TW_WIDTH-1:TH]};
    if (tw[TH-1:0] == {1'b1, {(TH-1){1'b0}}} && tw[TW_WIDTH-1:TH] == '0)
      wr_in = {2'b01, {(TH-1){1'b0}}};
  end

  always_comb begin
    if (INVERSE == 0) begin
      sum_r = ext_p(s2_rr) + ext_p(s2_ii);
      sum_i = ext_p(s2_ir) - ext_p(s2_ri);
    end else begin
      sum_r = ext_p(s2_rr) - ext_p(s2_ii);
      sum_i = ext_p(s2_ir) + ext_p(s2_ri);
    end
    sh_r = sum_r >>> (TH - 1);
    sh_i = sum_i >>> (TH - 1);
  end

  always_comb begin
    ea_r = {{2{s3_ar[H-1]}}, s3_ar};
    ea_i = {{2{s3_ai[H-1]}}, s3_ai};
    xs_r = ea_r + s3_tr;
    xs_i = ea_i + s3_ti;
    ys_r = ea_r - s3_tr;
    ys_i = ea_i - s3_ti;
`ifdef BFLY_SCALE_EN
    xs_r = (xs_r + RW'(1)) >>> 1;
    xs_i = (xs_i + RW'(1)) >>> 1;
    ys_r = (ys_r + RW'(1)) >>> 1;
    ys_i = (ys_i + RW'(1)) >>> 1;
`endif
    xr_s   = sat_h(xs_r);
    xi_s   = sat_h(xs_i);
    yr_s   = sat_h(ys_r);
    yi_s   = sat_h(ys_i);
    sat_ev = xr_s[H] | xi_s[H] | yr_s[H] | yi_s[H];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {v1, v2, v3, v4} <= '0;
      {s1_ar, s1_ai, s1_br, s1_bi} <= '0;
      {s1_wr, s1_wi} <= '0;
      {s2_ar, s2_ai} <= '0;
      {s2_rr, s2_ii, s2_ir, s2_ri} <= '0;
      {s3_ar, s3_ai, s3_tr, s3_ti} <= '0;
      x <= '0;
      y <= '0;
    end else if (en) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
      v4 <= v3;
      s1_ar <= a[H-1:0];
      s1_ai <= a[WIDTH-1:H];
      s1_br <= b[H-1:0];
      s1_bi <= b[WIDTH-1:H];
      s1_wr <= wr_in;
      s1_wi <= wi_in;
      s2_ar <= s1_ar;
      s2_ai <= s1_ai;
      s2_rr <= mul(s1_br, s1_wr);
      s2_ii <= mul(s1_bi, s1_wi);
      s2_ir <= mul(s1_bi, s1_wr);
      s2_ri <= mul(s1_br, s1_wi);
      s3_ar <= s2_ar;
      s3_ai <= s2_ai;
      s3_tr <= sh_r[RW-1:0];
      s3_ti <= sh_i[RW-1:0];
      x <= {xi_s[H-1:0], xr_s[H-1:0]};
      y <= {yi_s[H-1:0], yr_s[H-1:0]};
    end
  end

  // A saturation counts when a valid word is committed into the output stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      sat_flag <= 1'b0;
    else if (en && v3 && sat_ev)
      sat_flag <= 1'b1;
    else if (sat_clear)
      sat_flag <= 1'b0;
  end
endmodule
